dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the core load/store unit, port 1 is the DMA/debug loader.
- Sits between both requesters and the data memory. Drives the memory's MemRead, MemWrite, a, wd and Funct3 inputs, and consumes its combinational rd.
- Round-robin arbitration with optional burst locking. Read data is returned through a registered response one cycle after grant.

Parameters:
- DM_ADDRESS, 9, word-address width forwarded to the memory.
- DATA_W, 32, data width.
- MAX_BURST, 8, maximum consecutive locked grants before forced release (must be >= 1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_i  in  2  per-port request, bit n = port n
- we_i  in  2  per-port write (1) / read (0)
- lock_i  in  2  per-port request to keep ownership for the next access
- addr0_i, addr1_i  in  DM_ADDRESS  per-port word address
- wdata0_i, wdata1_i  in  DATA_W  per-port write data
- funct3_0_i, funct3_1_i  in  3  per-port access size (LB/LH/LW/LBU/LHU, SB/SH/SW encoding)
- gnt_o  out  2  one-hot grant; the access executes in this cycle
- rvalid_o  out  2  read response valid, one cycle after a read grant
- rdata_o  out  DATA_W  registered read data, shared by both ports
- MemRead  out  1  to memory
- MemWrite  out  1  to memory
- a  out  DM_ADDRESS  to memory
- wd  out  DATA_W  to memory
- Funct3  out  3  to memory
- rd  in  DATA_W  from memory (combinational read)

Behaviour:
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=0, MemRead=0, MemWrite=0, a=0, wd=0, Funct3=0. Internal state: FSM=IDLE, last_winner=1 (so port 0 wins first), burst_cnt=0.
- Grant is combinational from req_i and state. At most one gnt_o bit is high.
- Memory outputs are muxed from the granted port, and are all 0 when there is no grant.
  - MemWrite = gnt & we.
  - MemRead = gnt & ~we.
- Write commits at the clk edge ending the grant cycle.
- On a read grant, rd is captured into rdata_o at that edge and the matching rvalid_o bit is pulsed for exactly one cycle.
- Back-to-back reads give back-to-back rvalid pulses.

State machine:
- IDLE:
  - No ownership. The port requesting alone wins.
  - If both request, the port opposite last_winner wins.
  - Winner with lock_i set: go to OWN0 or OWN1, burst_cnt=1.
  - Otherwise: stay in IDLE and update last_winner.
- OWNn:
  - Port n has priority and the other port is blocked.
  - If req_i[n] & lock_i[n] & (burst_cnt < MAX_BURST): grant n, burst_cnt++, stay.
  - If req_i[n] & ~lock_i[n]: grant n as the final beat, go to IDLE, last_winner=n.
  - If ~req_i[n]: the other port may win this cycle under IDLE rules, go to IDLE, last_winner=n.
  - If burst_cnt == MAX_BURST while the other port is requesting: the other port wins this cycle and the state goes to IDLE, or to the other port's OWN state if its lock_i is set.
  - If burst_cnt == MAX_BURST and the other port is idle: port n continues with burst_cnt reset to 1.
- Boundary cases:
  - MAX_BURST=1: lock only extends ownership while the other port is idle.
  - Simultaneous requests with neither locked: strict alternation.
  - reset asserted mid-burst: immediately returns to the reset state. Any pending rvalid is dropped. A write already clocked stays committed.
  - Requests whose we_i or lock_i change while not granted are ignored until grant.

Optional Feature:
- DMEM_ARB_CORE_PRIO_EN
  - Defined: port 0 always wins when it requests in IDLE, and it preempts port 1 ownership immediately. The lock and burst limit apply to port 0 only; lock_i[1] is ignored.
  - Undefined: round-robin and lock behaviour as specified above.

Decomposition:
- Package dmem_arb_pkg holds:
  - enum arb_state_e {IDLE, OWN0, OWN1};
  - Funct3 localparams (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU);
  - NUM_PORTS=2.
- One natural sub-module: rr_pick2, the two-input round-robin picker (req, last_winner -> one-hot). Used only in IDLE decisions.

Test Plan:
- Port 0 SW addr=5 wdata=0xDEADBEEF, then port 1 LW addr=5 -> gnt_o=01 then 10; rvalid_o[1] pulses the next cycle with rdata_o=0xDEADBEEF.
- Both ports read continuously, no lock -> gnt_o alternates 01,10,01,10; each rvalid follows its grant by exactly 1 cycle.
- Port 1 locked with 12 reads, port 0 requesting throughout, MAX_BURST=8 -> 8 port-1 grants, then one port-0 grant, then port 1 resumes.
- Port 0 LB at a byte holding 0x80 -> rdata_o=0xFFFFFF80. LBU at the same byte -> 0x00000080. SH 0x1234 then LW -> low half 0x1234.
- reset pulse during the 3rd beat of a port-0 locked burst -> all outputs 0 asynchronously. After release, port 0 wins the first contested cycle.
- With DMEM_ARB_CORE_PRIO_EN defined, port 1 locked and port 0 requesting -> port 0 is granted the same cycle it raises req_i[0].

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter:
//   - NUM_PORTS          : number of requesters (core LSU = 0, DMA/debug = 1)
//   - arb_state_e        : ownership states of the arbiter FSM
//   - F3_*               : access-size encodings forwarded on Funct3
//   - port_onehot()      : port index -> one-hot grant vector
//   - own_state()        : port index -> matching ownership state code
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  // Loads use all five codes; stores reuse LB/LH/LW as SB/SH/SW.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [1:0] own_state(input logic idx);
    return idx ? 2'(OWN1) : 2'(OWN0);
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Two-input round-robin picker used for ownerless (IDLE) arbitration.
// A lone requester wins outright; when both request, the port that did not
// win last time is chosen.
// Ports:
//   i_req         [NUM_PORTS] request vector, bit n = port n
//   i_last_winner [1]         index of the previous winner
//   o_gnt         [NUM_PORTS] one-hot pick (all zero when nobody requests)
// -----------------------------------------------------------------------------
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_last_winner,
  output logic [NUM_PORTS-1:0] o_gnt
);

  // Pick the requester, alternating on contention.
  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last_winner ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares a single-port data memory between the core load/store unit (port 0)
// and the DMA/debug loader (port 1). Grants are combinational so the access
// executes in the grant cycle; writes commit at the closing clock edge and
// read data is captured into a shared registered response (rdata_o) with a
// one-cycle rvalid_o pulse on the matching port.
//
// Arbitration: round-robin while nobody owns the memory; a winner with lock_i
// set takes ownership for consecutive beats, bounded by MAX_BURST when the
// other port is waiting.
//
// Build option: define DMEM_ARB_CORE_PRIO_EN to give port 0 strict priority.
// Port 0 then always wins in IDLE, lock_i[1] is ignored (so port 1 can never
// own the memory and port 0 is never held off), and lock/burst limits apply
// to port 0 only.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_i, we_i, lock_i  [2]   per-port request / write / keep-ownership
//   addr0_i, addr1_i     [DM_ADDRESS]  per-port word address
//   wdata0_i, wdata1_i   [DATA_W]      per-port write data
//   funct3_0_i, funct3_1_i [3]         per-port access size
//   gnt_o                [2]   one-hot grant (access happens this cycle)
//   rvalid_o             [2]   read response valid, one cycle after grant
//   rdata_o              [DATA_W] registered read data
//   MemRead, MemWrite, a, wd, Funct3   memory command outputs
//   rd                   [DATA_W] combinational memory read data
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_PORTS-1:0]  req_i,
  input  logic [NUM_PORTS-1:0]  we_i,
  input  logic [NUM_PORTS-1:0]  lock_i,
  input  logic [DM_ADDRESS-1:0] addr0_i,
  input  logic [DM_ADDRESS-1:0] addr1_i,
  input  logic [DATA_W-1:0]     wdata0_i,
  input  logic [DATA_W-1:0]     wdata1_i,
  input  logic [2:0]            funct3_0_i,
  input  logic [2:0]            funct3_1_i,
  output logic [NUM_PORTS-1:0]  gnt_o,
  output logic [NUM_PORTS-1:0]  rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  output logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     rd
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_OWN0 = 2'(OWN0);
  localparam logic [1:0] ST_OWN1 = 2'(OWN1);

  // Counter must hold MAX_BURST itself.
  localparam int                CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  logic [1:0]           r_state;
  logic                 r_last_winner;
  logic [CNT_W-1:0]     r_burst_cnt;
  logic [NUM_PORTS-1:0] r_rvalid;
  logic [DATA_W-1:0]    r_rdata;

  logic [NUM_PORTS-1:0] w_lock;
  logic                 w_pick_last;
  logic [NUM_PORTS-1:0] w_idle_gnt;
  logic                 w_idle_win;
  logic                 w_own;
  logic                 w_oth;
  logic                 w_at_max;
  logic                 w_handoff;
  logic [NUM_PORTS-1:0] w_gnt_raw;
  logic [NUM_PORTS-1:0] w_gnt;
  logic [1:0]           w_nxt_state;
  logic                 w_nxt_last;
  logic [CNT_W-1:0]     w_nxt_cnt;

`ifdef DMEM_ARB_CORE_PRIO_EN
  // Masking lock_i[1] keeps port 1 out of OWN1; pinning last_winner to 1
  // turns the round-robin picker into fixed port-0 priority.
  assign w_lock      = lock_i & 2'b01;
  assign w_pick_last = 1'b1;
`else
  assign w_lock      = lock_i;
  assign w_pick_last = r_last_winner;
`endif

  rr_pick2 u_rr_pick2 (
    .i_req         (req_i),
    .i_last_winner (w_pick_last),
    .o_gnt         (w_idle_gnt)
  );

  assign w_idle_win = w_idle_gnt[1];
  assign w_own      = (r_state == ST_OWN1);
  assign w_oth      = ~w_own;
  assign w_at_max   = (r_burst_cnt >= CNT_MAX);
  // The waiting port takes over when the burst is exhausted, or when the
  // owner drops its request (ownerless rules then leave it as sole requester).
  assign w_handoff  = req_i[w_oth] & (w_at_max | ~req_i[w_own]);

  // Grant decision and next ownership state.
  always_comb begin
    w_gnt_raw   = 2'b00;
    w_nxt_state = r_state;
    w_nxt_last  = r_last_winner;
    w_nxt_cnt   = r_burst_cnt;
    case (r_state)
      ST_IDLE: begin
        w_gnt_raw = w_idle_gnt;
        if (w_idle_gnt != 2'b00) begin
          if (w_lock[w_idle_win]) begin
            w_nxt_state = own_state(w_idle_win);
            w_nxt_cnt   = CNT_ONE;
          end else begin
            w_nxt_state = ST_IDLE;
            w_nxt_last  = w_idle_win;
          end
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (w_handoff) begin
          w_gnt_raw = port_onehot(w_oth);
          if (w_lock[w_oth]) begin
            w_nxt_state = own_state(w_oth);
            w_nxt_cnt   = CNT_ONE;
          end else begin
            w_nxt_state = ST_IDLE;
            w_nxt_last  = w_oth;
          end
        end else if (req_i[w_own]) begin
          w_gnt_raw = port_onehot(w_own);
          if (w_lock[w_own]) begin
            // Only reachable at the limit when the other port is idle:
            // ownership continues with a fresh burst.
            w_nxt_cnt = w_at_max ? CNT_ONE : (r_burst_cnt + CNT_ONE);
          end else begin
            w_nxt_state = ST_IDLE;
            w_nxt_last  = w_own;
          end
        end else begin
          w_nxt_state = ST_IDLE;
          w_nxt_last  = w_own;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_cnt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Reset forces the combinational grant low so the memory sees no access.
  assign w_gnt = reset ? 2'b00 : w_gnt_raw;

  assign MemWrite = |(w_gnt & we_i);
  assign MemRead  = |(w_gnt & ~we_i);

  // Forward the granted port's command; zeros when nothing is granted.
  always_comb begin
    a      = {DM_ADDRESS{1'b0}};
    wd     = {DATA_W{1'b0}};
    Funct3 = 3'b000;
    if (w_gnt[0]) begin
      a      = addr0_i;
      wd     = wdata0_i;
      Funct3 = funct3_0_i;
    end else if (w_gnt[1]) begin
      a      = addr1_i;
      wd     = wdata1_i;
      Funct3 = funct3_1_i;
    end else begin
      a      = {DM_ADDRESS{1'b0}};
      wd     = {DATA_W{1'b0}};
      Funct3 = 3'b000;
    end
  end

  // Arbitration state and registered read response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_last_winner <= 1'b1;
      r_burst_cnt   <= {CNT_W{1'b0}};
      r_rvalid      <= 2'b00;
      r_rdata       <= {DATA_W{1'b0}};
    end else begin
      r_state       <= w_nxt_state;
      r_last_winner <= w_nxt_last;
      r_burst_cnt   <= w_nxt_cnt;
      r_rvalid      <= w_gnt & ~we_i;
      if (MemRead) begin
        r_rdata <= rd;
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  assign gnt_o    = w_gnt;
  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. A behavioural data memory sits on the
// DUT's memory port; a reference model (owner index, beat count, last winner,
// shadow memory) predicts grants, memory commands and read responses.
// Directed table vectors, hand-written burst/reset sequences, then random
// traffic are all checked against the model.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW   = 9;
  localparam int DW   = 32;
  localparam int MAXB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_i, we_i, lock_i;
  logic [AW-1:0] addr0_i, addr1_i;
  logic [DW-1:0] wdata0_i, wdata1_i;
  logic [2:0]    funct3_0_i, funct3_1_i;
  logic [1:0]    gnt_o, rvalid_o;
  logic [DW-1:0] rdata_o;
  logic          MemRead, MemWrite;
  logic [AW-1:0] a;
  logic [DW-1:0] wd;
  logic [2:0]    Funct3;
  logic [DW-1:0] rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .funct3_0_i(funct3_0_i), .funct3_1_i(funct3_1_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .MemRead(MemRead), .MemWrite(MemWrite),
    .a(a), .wd(wd), .Funct3(Funct3), .rd(rd)
  );

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [2:0] f);
    case (f)
      F3_LB:   return {{24{w[7]}}, w[7:0]};
      F3_LH:   return {{16{w[15]}}, w[15:0]};
      F3_LBU:  return {24'h000000, w[7:0]};
      F3_LHU:  return {16'h0000, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] old, input logic [31:0] d,
                                            input logic [2:0] f);
    case (f)
      F3_LB:   return {old[31:8], d[7:0]};
      F3_LH:   return {old[31:16], d[15:0]};
      default: return d;
    endcase
  endfunction

  // Environment memory driven by the DUT's memory port.
  logic [31:0] mem [0:511];
  assign rd = load_val(mem[a], Funct3);
  always @(posedge clk) begin
    if (MemWrite) mem[a] <= store_val(mem[a], wd, Funct3);
  end

  // Reference model state.
  int          m_owner, m_beats, m_last;
  logic [1:0]  m_rvalid;
  logic [31:0] m_rdata;
  logic [31:0] ref_mem [0:511];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = -1;
    m_beats  = 0;
    m_last   = 1;
    m_rvalid = 2'b00;
    m_rdata  = 32'h0;
  endtask

  function automatic bit lock_eff(input logic [1:0] lk, input int p);
`ifdef DMEM_ARB_CORE_PRIO_EN
    if (p == 1) return 1'b0;
`endif
    return lk[p];
  endfunction

  function automatic int idle_winner(input logic [1:0] rq);
`ifdef DMEM_ARB_CORE_PRIO_EN
    if (rq[0]) return 0;
    if (rq[1]) return 1;
    return -1;
`else
    if (rq == 2'b11) return (m_last == 0) ? 1 : 0;
    if (rq[0]) return 0;
    if (rq[1]) return 1;
    return -1;
`endif
  endfunction

  // One bus cycle: drive, check against model, advance model, step clock.
  task automatic cycle(input logic [1:0] rq, wq, lk, input logic [8:0] ad0, ad1,
                       input logic [31:0] d0, d1, input logic [2:0] f0, f1,
                       input string tag,
                       output logic [1:0] o_g, output logic [1:0] o_rv, output logic [31:0] o_rd);
    int          w, n, o;
    logic [1:0]  eg;
    logic [45:0] eb;
    logic [8:0]  ad;
    logic [31:0] dd;
    logic [2:0]  ff;
    req_i = rq; we_i = wq; lock_i = lk;
    addr0_i = ad0; addr1_i = ad1; wdata0_i = d0; wdata1_i = d1;
    funct3_0_i = f0; funct3_1_i = f1;
    #4;
    if (m_owner < 0) begin
      w = idle_winner(rq);
    end else begin
      n = m_owner; o = 1 - n;
      if ((m_beats >= MAXB && rq[o]) || (!rq[n] && rq[o])) w = o;
      else if (rq[n]) w = n;
      else w = -1;
    end
    eg = (w < 0) ? 2'b00 : ((w == 0) ? 2'b01 : 2'b10);
    if (w < 0) begin
      eb = 46'h0; ad = 9'h0; dd = 32'h0; ff = 3'b000;
    end else begin
      ad = (w == 0) ? ad0 : ad1;
      dd = (w == 0) ? d0 : d1;
      ff = (w == 0) ? f0 : f1;
      eb = {~wq[w], wq[w], ad, dd, ff};
    end
    chk({tag, " gnt"}, 64'(gnt_o), 64'(eg));
    chk({tag, " membus"}, 64'({MemRead, MemWrite, a, wd, Funct3}), 64'(eb));
    chk({tag, " rvalid"}, 64'(rvalid_o), 64'(m_rvalid));
    chk({tag, " rdata"}, 64'(rdata_o), 64'(m_rdata));
    o_g = gnt_o; o_rv = rvalid_o; o_rd = rdata_o;
    // Advance the reference model.
    m_rvalid = 2'b00;
    if (w >= 0) begin
      if (wq[w]) ref_mem[ad] = store_val(ref_mem[ad], dd, ff);
      else begin
        m_rvalid[w] = 1'b1;
        m_rdata = load_val(ref_mem[ad], ff);
      end
    end
    if (m_owner >= 0 && w == m_owner) begin
      if (lock_eff(lk, w)) m_beats = (m_beats >= MAXB) ? 1 : m_beats + 1;
      else begin m_owner = -1; m_last = w; end
    end else if (w >= 0) begin
      if (lock_eff(lk, w)) begin m_owner = w; m_beats = 1; end
      else begin m_owner = -1; m_last = w; end
    end else begin
      if (m_owner >= 0) m_last = m_owner;
      m_owner = -1;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  req, we, lock;
    logic [8:0]  a0, a1;
    logic [31:0] d0, d1;
    logic [2:0]  f0, f1;
    logic [1:0]  exp_gnt, exp_rv;
    bit          chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [0:14];

  initial begin
    logic [1:0]  g, rv, rq, wq, lk, eg;
    logic [31:0] rdv;
    logic [2:0]  f0, f1;
    logic [2:0]  rd_codes [0:4];
    rd_codes[0] = F3_LB; rd_codes[1] = F3_LH; rd_codes[2] = F3_LW;
    rd_codes[3] = F3_LBU; rd_codes[4] = F3_LHU;
    for (int i = 0; i < 512; i++) begin
      mem[i] <= 32'h0;
      ref_mem[i] = 32'h0;
    end
    model_reset();

    // Reset: outputs must be zero even with requests pending.
    reset = 1'b1; req_i = 2'b11; we_i = 2'b01; lock_i = 2'b11;
    addr0_i = 9'h1F; addr1_i = 9'h2A; wdata0_i = 32'h12345678; wdata1_i = 32'h9ABCDEF0;
    funct3_0_i = F3_LW; funct3_1_i = F3_LW;
    #12;
    chk("reset gnt", 64'(gnt_o), 64'h0);
    chk("reset membus", 64'({MemRead, MemWrite, a, wd, Funct3}), 64'h0);
    chk("reset rvalid", 64'(rvalid_o), 64'h0);
    chk("reset rdata", 64'(rdata_o), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;

`ifdef DMEM_ARB_CORE_PRIO_EN
    cycle(2'b10, 2'b00, 2'b10, 9'd0, 9'd3, 32'h0, 32'h0, F3_LW, F3_LW, "prio p1", g, rv, rdv);
    chk("prio p1 alone", 64'(g), 64'h2);
    cycle(2'b11, 2'b00, 2'b10, 9'd1, 9'd3, 32'h0, 32'h0, F3_LW, F3_LW, "prio p0", g, rv, rdv);
    chk("prio p0 preempt", 64'(g), 64'h1);
`else
    //          req    we     lock   a0    a1    d0            d1     f0      f1     gnt    rv     chk   rdata
    tbl[0]  = '{2'b01, 2'b01, 2'b00, 9'd5, 9'd0, 32'hDEADBEEF, 32'h0, F3_LW,  F3_LW, 2'b01, 2'b00, 1'b0, 32'h0};
    tbl[1]  = '{2'b10, 2'b00, 2'b00, 9'd0, 9'd5, 32'h0,       32'h0, F3_LW,  F3_LW, 2'b10, 2'b00, 1'b0, 32'h0};
    tbl[2]  = '{2'b00, 2'b00, 2'b00, 9'd0, 9'd0, 32'h0,       32'h0, F3_LW,  F3_LW, 2'b00, 2'b10, 1'b1, 32'hDEADBEEF};
    tbl[3]  = '{2'b11, 2'b00, 2'b00, 9'd1, 9'd2, 32'h0,       32'h0, F3_LW,  F3_LW, 2'b01, 2'b00, 1'b0, 32'h0};
    tbl[4]  = '{2'b11, 2'b00, 2'b00, 9'd1, 9'd2, 32'h0,       32'h0, F3_LW,  F3_LW, 2'b10, 2'b01, 1'b0, 32'h0};
    tbl[5]  = '{2'b11, 2'b00, 2'b00, 9'd1, 9'd2, 32'h0,       32'h0, F3_LW,  F3_LW, 2'b01, 2'b10, 1'b0, 32'h0};
    tbl[6]  = '{2'b11, 2'b00, 2'b00, 9'd1, 9'd2, 32'h0,       32'h0, F3_LW,  F3_LW, 2'b10, 2'b01, 1'b0, 32'h0};
    tbl[7]  = '{2'b00, 2'b00, 2'b00, 9'd0, 9'd0, 32'h0,       32'h0, F3_LW,  F3_LW, 2'b00, 2'b10, 1'b0, 32'h0};
    tbl[8]  = '{2'b01, 2'b01, 2'b00, 9'd7, 9'd0, 32'h00000080, 32'h0, F3_LW, F3_LW, 2'b01, 2'b00, 1'b0, 32'h0};
    tbl[9]  = '{2'b01, 2'b00, 2'b00, 9'd7, 9'd0, 32'h0,       32'h0, F3_LB,  F3_LW, 2'b01, 2'b00, 1'b0, 32'h0};
    tbl[10] = '{2'b01, 2'b00, 2'b00, 9'd7, 9'd0, 32'h0,       32'h0, F3_LBU, F3_LW, 2'b01, 2'b01, 1'b1, 32'hFFFFFF80};
    tbl[11] = '{2'b01, 2'b01, 2'b00, 9'd8, 9'd0, 32'hCAFEF00D, 32'h0, F3_LW, F3_LW, 2'b01, 2'b01, 1'b1, 32'h00000080};
    tbl[12] = '{2'b01, 2'b01, 2'b00, 9'd8, 9'd0, 32'h00001234, 32'h0, F3_LH, F3_LW, 2'b01, 2'b00, 1'b0, 32'h0};
    tbl[13] = '{2'b01, 2'b00, 2'b00, 9'd8, 9'd0, 32'h0,       32'h0, F3_LW,  F3_LW, 2'b01, 2'b00, 1'b0, 32'h0};
    tbl[14] = '{2'b00, 2'b00, 2'b00, 9'd0, 9'd0, 32'h0,       32'h0, F3_LW,  F3_LW, 2'b00, 2'b01, 1'b1, 32'hCAFE1234};
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].req, tbl[i].we, tbl[i].lock, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1,
            tbl[i].f0, tbl[i].f1, $sformatf("tbl%0d", i), g, rv, rdv);
      chk($sformatf("tbl%0d exp gnt", i), 64'(g), 64'(tbl[i].exp_gnt));
      chk($sformatf("tbl%0d exp rvalid", i), 64'(rv), 64'(tbl[i].exp_rv));
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d exp rdata", i), 64'(rdv), 64'(tbl[i].exp_rd));
    end

    // Port 1 locked for 12 reads with port 0 waiting: 8 beats, one port-0 beat, then 4 more.
    for (int k = 0; k < 14; k++) begin
      rq = (k == 0) ? 2'b10 : ((k == 13) ? 2'b01 : 2'b11);
      eg = (k < 8) ? 2'b10 : ((k == 8) ? 2'b01 : ((k < 13) ? 2'b10 : 2'b01));
      cycle(rq, 2'b00, 2'b10, 9'd5, 9'(k), 32'h0, 32'h0, F3_LW, F3_LW,
            $sformatf("burst%0d", k), g, rv, rdv);
      chk($sformatf("burst%0d exp gnt", k), 64'(g), 64'(eg));
    end
`endif

    // Reset during the third beat of a port-0 locked read burst.
    cycle(2'b01, 2'b00, 2'b01, 9'd5, 9'd0, 32'h0, 32'h0, F3_LW, F3_LW, "rstb1", g, rv, rdv);
    cycle(2'b01, 2'b00, 2'b01, 9'd5, 9'd0, 32'h0, 32'h0, F3_LW, F3_LW, "rstb2", g, rv, rdv);
    #1;
    chk("rstb3 pending rvalid", 64'(rvalid_o), 64'h1);
    chk("rstb3 pending rdata", 64'(rdata_o), 64'hDEADBEEF);
    #1 reset = 1'b1;
    #1;
    chk("midrst gnt", 64'(gnt_o), 64'h0);
    chk("midrst membus", 64'({MemRead, MemWrite, a, wd, Funct3}), 64'h0);
    chk("midrst rvalid", 64'(rvalid_o), 64'h0);
    chk("midrst rdata", 64'(rdata_o), 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    cycle(2'b11, 2'b00, 2'b00, 9'd5, 9'd8, 32'h0, 32'h0, F3_LW, F3_LW, "postrst", g, rv, rdv);
    chk("postrst p0 first", 64'(g), 64'h1);

    // Random traffic against the reference model; busy requests/locks reach the burst limit.
    for (int r = 0; r < 600; r++) begin
      rq = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      lk = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      wq = 2'($urandom_range(0, 3));
      f0 = wq[0] ? 3'($urandom_range(0, 2)) : rd_codes[$urandom_range(0, 4)];
      f1 = wq[1] ? 3'($urandom_range(0, 2)) : rd_codes[$urandom_range(0, 4)];
      cycle(rq, wq, lk, 9'($urandom_range(0, 15)), 9'($urandom_range(0, 15)),
            $urandom, $urandom, f0, f1, $sformatf("rnd%0d", r), g, rv, rdv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
